act_quant_pipe: RTL and testbench

//  Parametrised activation + requantisation stage between MAC accumulators and feature write-back.

---
 rtl/act_quant_pipe_if.sv | 32 +++
 rtl/act_quant_pipe.sv | 195 +++++++++++++++++++
 tb/tb_act_quant_pipe.sv | 540 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_quant_pipe_if.sv
// Purpose: stream bundle for act_quant_pipe. It carries the accumulator beat going in and the
//          packed feature beat coming out, each with its own valid/ready handshake.
// Signals:
//   data_in        LANES*MAC_OUTPUT_WIDTH  accumulator beat, lane i at [i*MAC_OUTPUT_WIDTH +: ...]
//   data_in_valid  1                       input beat valid
//   data_in_ready  1                       input beat accepted when valid & ready
//   act_data       LANES*FEATURE_WIDTH     feature beat, lane i at [i*FEATURE_WIDTH +: ...]
//   act_data_valid 1                       output beat valid
//   act_data_ready 1                       downstream accepts the output beat
// Modports: master = producer/consumer side (testbench or MAC array), slave = the quant stage.
interface act_quant_pipe_if #(
    parameter int unsigned LANES            = 8,
    parameter int unsigned MAC_OUTPUT_WIDTH = 36,
    parameter int unsigned FEATURE_WIDTH    = 16
);
    logic [LANES*MAC_OUTPUT_WIDTH-1:0] data_in;
    logic                              data_in_valid;
    logic                              data_in_ready;
    logic [LANES*FEATURE_WIDTH-1:0]    act_data;
    logic                              act_data_valid;
    logic                              act_data_ready;

    modport master (
        output data_in, data_in_valid, act_data_ready,
        input  data_in_ready, act_data, act_data_valid
    );

    modport slave (
        input  data_in, data_in_valid, act_data_ready,
        output data_in_ready, act_data, act_data_valid
    );
endinterface

// File: rtl/act_quant_pipe.sv
// Purpose: activation + requantisation stage between the MAC accumulators and feature
//          write-back. Three pipeline stages with a single global advance:
//            S1 activation (bypass / ReLU / leaky ReLU / ReLU-clip)
//            S2 optional round-half-up, arithmetic right shift by the quantisation difference
//            S3 saturate or wrap to FEATURE_WIDTH, optional clip, pack into act_data
// Ports:
//   system_clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   cfg_load, cfg_*            layer configuration, latched only while the pipeline is empty
//   bus (slave)                input accumulator stream and output feature stream
//   busy                       any stage holds a beat
//   cfg_err                    sticky: refused cfg_load, or negative shift at latch
//   sat_count                  lanes saturated since reset, sticks at all-ones
module act_quant_pipe #(
    parameter int unsigned LANES            = 8,
    parameter int unsigned MAC_OUTPUT_WIDTH = 36,
    parameter int unsigned FEATURE_WIDTH    = 16,
    parameter int unsigned SATCNT_WIDTH     = 32
) (
    input  logic                     system_clk,
    input  logic                     rst_n,
    input  logic                     cfg_load,
    input  logic [1:0]               cfg_act_mode,
    input  logic [2:0]               cfg_leaky_shift,
    input  logic [3:0]               cfg_fea_in_q,
    input  logic [3:0]               cfg_weight_q,
    input  logic [3:0]               cfg_fea_out_q,
    input  logic                     cfg_round_en,
    input  logic                     cfg_sat_en,
    input  logic [FEATURE_WIDTH-1:0] cfg_clip_max,
    act_quant_pipe_if.slave          bus,
    output logic                     busy,
    output logic                     cfg_err,
    output logic [SATCNT_WIDTH-1:0]  sat_count
);
    localparam int unsigned MW   = MAC_OUTPUT_WIDTH;
    localparam int unsigned FW   = FEATURE_WIDTH;
    localparam int unsigned CntW = $clog2(LANES + 1);

    localparam logic signed [FW-1:0] FeaMax = {1'b0, {(FW-1){1'b1}}};
    localparam logic signed [FW-1:0] FeaMin = {1'b1, {(FW-1){1'b0}}};

    typedef enum logic [1:0] {
        ModeBypass = 2'd0,
        ModeRelu   = 2'd1,
        ModeLeaky  = 2'd2,
        ModeClip   = 2'd3
    } act_mode_e;

    // Layer configuration
    act_mode_e             mode_q;
    logic [2:0]            leaky_q;
    logic [4:0]            shift_q;
    logic                  round_q;
    logic                  sat_q;
    logic signed [FW-1:0]  clip_q;
    logic                  cfg_err_q;

    // Pipeline state
    logic                  s1_valid_q, s2_valid_q, out_valid_q;
    logic signed [MW-1:0]  s1_q [LANES];
    logic signed [MW-1:0]  s1_d [LANES];
    logic signed [MW:0]    s2_q [LANES];
    logic signed [MW:0]    s2_d [LANES];
    logic [LANES*FW-1:0]   out_q, out_d;
    logic [CntW-1:0]       sat_hits;
    logic [SATCNT_WIDTH-1:0] sat_count_q;
    logic [SATCNT_WIDTH:0]   sat_sum;

    logic                  adv, accept, cfg_take, cfg_reject;
    logic signed [5:0]     shift_calc;
    logic signed [MW:0]    rnd_add;

    assign adv    = ~out_valid_q | bus.act_data_ready;
    assign accept = bus.data_in_valid & adv;
    assign busy   = s1_valid_q | s2_valid_q | out_valid_q;

    // A load that coincides with an accepted beat is refused so that no beat ever sees a
    // configuration change mid-flight.
    assign cfg_take   = cfg_load & ~busy & ~accept;
    assign cfg_reject = cfg_load & ~cfg_take;

    assign shift_calc = $signed({2'b00, cfg_fea_in_q}) + $signed({2'b00, cfg_weight_q})
                      - $signed({2'b00, cfg_fea_out_q});

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= ModeBypass;
            leaky_q   <= '0;
            shift_q   <= '0;
            round_q   <= 1'b0;
            sat_q     <= 1'b0;
            clip_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (cfg_take) begin
                mode_q  <= act_mode_e'(cfg_act_mode);
                leaky_q <= cfg_leaky_shift;
                shift_q <= shift_calc[5] ? 5'd0 : shift_calc[4:0];
                round_q <= cfg_round_en;
                sat_q   <= cfg_sat_en;
                clip_q  <= $signed(cfg_clip_max);
            end
            if (cfg_reject || (cfg_take && shift_calc[5])) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    // S1: activation on the incoming beat
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_d[i] = $signed(bus.data_in[i*MW +: MW]);
            case (mode_q)
                ModeRelu, ModeClip: if (s1_d[i] < 0) s1_d[i] = '0;
                ModeLeaky:          if (s1_d[i] < 0) s1_d[i] = s1_d[i] >>> leaky_q;
                default:            ;
            endcase
        end
    end

    // S2: one extra bit of headroom so the rounding increment cannot overflow
    always_comb begin
        rnd_add = '0;
        if (round_q && (shift_q != 5'd0)) begin
            rnd_add = signed'((MW+1)'(1) << (shift_q - 5'd1));
        end
        for (int i = 0; i < LANES; i++) begin
            s2_d[i] = s1_q[i];
            s2_d[i] = s2_d[i] + rnd_add;
            s2_d[i] = s2_d[i] >>> shift_q;
        end
    end

    // S3: saturate (counted) or wrap, then the clip of mode 3 (never counted)
    always_comb begin
        out_d    = '0;
        sat_hits = '0;
        for (int i = 0; i < LANES; i++) begin
            logic signed [FW-1:0] y;
            logic                 hit;
            y   = s2_q[i][FW-1:0];
            hit = 1'b0;
            if (sat_q) begin
                if (s2_q[i] > FeaMax) begin
                    y   = FeaMax;
                    hit = 1'b1;
                end else if (s2_q[i] < FeaMin) begin
                    y   = FeaMin;
                    hit = 1'b1;
                end
            end
            if (mode_q == ModeClip) begin
                if (y < 0) begin
                    y = '0;
                end else if (y > clip_q) begin
                    y = clip_q;
                end
            end
            out_d[i*FW +: FW] = y;
            sat_hits          = sat_hits + CntW'(hit);
        end
    end

    assign sat_sum = {1'b0, sat_count_q} + (SATCNT_WIDTH+1)'(sat_hits);

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            sat_count_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
            end
        end else if (adv) begin
            s1_valid_q  <= bus.data_in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (bus.data_in_valid) s1_q <= s1_d;
            if (s1_valid_q)        s2_q <= s2_d;
            if (s2_valid_q) begin
                out_q       <= out_d;
                sat_count_q <= sat_sum[SATCNT_WIDTH] ? '1 : sat_sum[SATCNT_WIDTH-1:0];
            end
        end
    end

    assign bus.data_in_ready  = adv;
    assign bus.act_data       = out_q;
    assign bus.act_data_valid = out_valid_q;
    assign cfg_err            = cfg_err_q;
    assign sat_count          = sat_count_q;
endmodule

// File: tb/tb_act_quant_pipe.sv
// Directed bench for act_quant_pipe plus one randomised backpressure run against a lane model.
module tb_act_quant_pipe;
    localparam int LANES = 8;
    localparam int MW    = 36;
    localparam int FW    = 16;
    localparam int NB    = 1000;

    logic              system_clk = 1'b0;
    logic              rst_n;
    logic              cfg_load;
    logic [1:0]        cfg_act_mode;
    logic [2:0]        cfg_leaky_shift;
    logic [3:0]        cfg_fea_in_q, cfg_weight_q, cfg_fea_out_q;
    logic              cfg_round_en, cfg_sat_en;
    logic [FW-1:0]     cfg_clip_max;
    logic              busy, cfg_err;
    logic [31:0]       sat_count;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [31:0]       exp_sat;
    longint            lv [LANES];
    longint            ev [LANES];
    logic [LANES*FW-1:0] res, expv;
    int                lat;

    act_quant_pipe_if #(.LANES(LANES), .MAC_OUTPUT_WIDTH(MW), .FEATURE_WIDTH(FW)) bus ();

    act_quant_pipe #(
        .LANES(LANES), .MAC_OUTPUT_WIDTH(MW), .FEATURE_WIDTH(FW), .SATCNT_WIDTH(32)
    ) dut (
        .system_clk     (system_clk),
        .rst_n          (rst_n),
        .cfg_load       (cfg_load),
        .cfg_act_mode   (cfg_act_mode),
        .cfg_leaky_shift(cfg_leaky_shift),
        .cfg_fea_in_q   (cfg_fea_in_q),
        .cfg_weight_q   (cfg_weight_q),
        .cfg_fea_out_q  (cfg_fea_out_q),
        .cfg_round_en   (cfg_round_en),
        .cfg_sat_en     (cfg_sat_en),
        .cfg_clip_max   (cfg_clip_max),
        .bus            (bus),
        .busy           (busy),
        .cfg_err        (cfg_err),
        .sat_count      (sat_count)
    );

    always #5 system_clk = ~system_clk;

    function automatic logic [LANES*MW-1:0] pack_in();
        logic [LANES*MW-1:0] d;
        longint t;
        for (int i = 0; i < LANES; i++) begin
            t = lv[i];
            d[i*MW +: MW] = t[MW-1:0];
        end
        return d;
    endfunction

    function automatic logic [LANES*FW-1:0] pack_out();
        logic [LANES*FW-1:0] d;
        longint t;
        for (int i = 0; i < LANES; i++) begin
            t = ev[i];
            d[i*FW +: FW] = t[FW-1:0];
        end
        return d;
    endfunction

    // Reference for one lane in plain integer arithmetic
    function automatic logic [FW-1:0] model_lane(input longint x, input int mode, input int lk,
                                                 input int sh, input bit rnd, input bit sat,
                                                 input longint clip, output int hit);
        longint a;
        logic [FW-1:0] lo;
        a   = x;
        hit = 0;
        if ((mode == 1 || mode == 3) && a < 0) a = 0;
        if (mode == 2 && a < 0) a = a >>> lk;
        if (rnd && sh > 0) a = a + (longint'(1) << (sh - 1));
        a = a >>> sh;
        if (sat && a > 32767) begin
            a = 32767;
            hit = 1;
        end else if (sat && a < -32768) begin
            a = -32768;
            hit = 1;
        end
        lo = a[FW-1:0];
        a  = longint'($signed(lo));
        if (mode == 3) begin
            if (a < 0) a = 0;
            else if (a > clip) a = clip;
        end
        lo = a[FW-1:0];
        return lo;
    endfunction

    task automatic apply_reset();
        @(negedge system_clk);
        rst_n              = 1'b0;
        cfg_load           = 1'b0;
        bus.data_in_valid  = 1'b0;
        bus.act_data_ready = 1'b1;
        exp_sat            = '0;
        repeat (2) @(posedge system_clk);
        @(negedge system_clk);
        rst_n = 1'b1;
    endtask

    task automatic load_cfg(input int mode, input int lk, input int fin, input int w,
                            input int fout, input bit rnd, input bit sat, input int clip);
        @(negedge system_clk);
        cfg_act_mode    = mode[1:0];
        cfg_leaky_shift = lk[2:0];
        cfg_fea_in_q    = fin[3:0];
        cfg_weight_q    = w[3:0];
        cfg_fea_out_q   = fout[3:0];
        cfg_round_en    = rnd;
        cfg_sat_en      = sat;
        cfg_clip_max    = clip[FW-1:0];
        cfg_load        = 1'b1;
        @(posedge system_clk);
        #1 cfg_load = 1'b0;
    endtask

    // Sends one beat into an empty pipe, waits for it (bounded) and lets it drain.
    task automatic run_beat(input logic [LANES*MW-1:0] d, output logic [LANES*FW-1:0] r,
                            output int l);
        @(negedge system_clk);
        bus.act_data_ready = 1'b1;
        bus.data_in        = d;
        bus.data_in_valid  = 1'b1;
        @(posedge system_clk);
        #1 bus.data_in_valid = 1'b0;
        l = 1;
        while (bus.act_data_valid !== 1'b1 && l < 20) begin
            @(posedge system_clk);
            #1 l++;
        end
        r = bus.act_data;
        n_cmp++;
        if (l >= 20) begin
            n_err++;
            $display("FAIL beat_timeout: waited %0d cycles, required output within 20", l);
        end
        @(posedge system_clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (bus.act_data_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: valid=%b busy=%b required 0 0", bus.act_data_valid, busy);
        end
        n_cmp++;
        if (bus.act_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0", bus.act_data);
        end
        n_cmp++;
        if (sat_count !== 32'd0 || cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: sat_count=%0d cfg_err=%b required 0 0", sat_count, cfg_err);
        end
        n_cmp++;
        if (bus.data_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 1", bus.data_in_ready);
        end
    endtask

    task automatic test_bypass();
        load_cfg(0, 0, 8, 8, 8, 1'b0, 1'b0, 0);
        lv = '{64'h1234, -768, 255, -256, 0, 0, 0, 0};
        ev = '{18, -3, 0, -1, 0, 0, 0, 0};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL bypass_latency: got %0d required 3", lat);
        end
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL bypass_data: got %h required %h", res, expv);
        end
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_cfg_err: got %b required 0", cfg_err);
        end
    endtask

    task automatic test_relu_leaky();
        load_cfg(1, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        lv = '{-5, 7, 0, -1, 100, -32768, 32767, 1};
        ev = '{0, 7, 0, 0, 100, 0, 32767, 1};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL relu_data: got %h required %h", res, expv);
        end
        load_cfg(2, 3, 0, 0, 0, 1'b0, 1'b0, 0);
        lv = '{-16, -1, 40, -17, -8, 0, -9, 16};
        ev = '{-2, -1, 40, -3, -1, 0, -2, 16};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL leaky_data: got %h required %h", res, expv);
        end
    endtask

    task automatic test_round_sat();
        load_cfg(0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
        lv = '{5, -5, 1, -1, 0, 0, 0, 0};
        ev = '{5, -5, 1, -1, 0, 0, 0, 0};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL round_shift0: got %h required %h", res, expv);
        end
        load_cfg(0, 0, 4, 0, 0, 1'b1, 1'b1, 0);
        lv = '{24, 23, -24, -25, 64'h7_0000_0000, -64'sd17179869184, 524272, 524288};
        ev = '{2, 1, -1, -2, 32767, -32768, 32767, 32767};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        exp_sat = exp_sat + 3;
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL round_sat_data: got %h required %h", res, expv);
        end
        n_cmp++;
        if (sat_count !== exp_sat) begin
            n_err++;
            $display("FAIL round_sat_count: got %0d required %0d", sat_count, exp_sat);
        end
    endtask

    task automatic test_clip_wrap();
        load_cfg(3, 0, 0, 0, 0, 1'b0, 1'b1, 16'h0600);
        lv = '{16'h0800, 16'h0100, -5, 16'h0600, 16'h0601, 0, 1, 16'h05FF};
        ev = '{16'h0600, 16'h0100, 0, 16'h0600, 16'h0600, 0, 1, 16'h05FF};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL clip_data: got %h required %h", res, expv);
        end
        n_cmp++;
        if (sat_count !== exp_sat) begin
            n_err++;
            $display("FAIL clip_sat_count: got %0d required %0d", sat_count, exp_sat);
        end
        load_cfg(0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        lv = '{64'h18000, 64'h7FFF, -64'sh8001, 64'h12345, 0, 0, 0, 0};
        ev = '{-32768, 32767, 32767, 64'h2345, 0, 0, 0, 0};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv || sat_count !== exp_sat) begin
            n_err++;
            $display("FAIL wrap_data: got %h cnt %0d required %h cnt %0d",
                     res, sat_count, expv, exp_sat);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] l0;
        bus.act_data_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge system_clk);
            bus.data_in       = '0;
            bus.data_in[MW-1:0] = MW'(c + 1);
            bus.data_in_valid = (c < 4);
            @(posedge system_clk);
            #1;
            l0 = bus.act_data[FW-1:0];
            if (c >= 2 && c < 6) begin
                n_cmp++;
                if (bus.act_data_valid !== 1'b1 || l0 !== FW'(c - 1)) begin
                    n_err++;
                    $display("FAIL b2b_beat%0d: valid=%b lane0=%h required 1 %h",
                             c - 2, bus.act_data_valid, l0, FW'(c - 1));
                end
            end else if (c == 6) begin
                n_cmp++;
                if (bus.act_data_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_tail: valid=%b required 0", bus.act_data_valid);
                end
            end
        end
    endtask

    task automatic test_random_backpressure();
        logic [LANES*MW-1:0] pend_d;
        logic [LANES*FW-1:0] pend_e, stall_data, e;
        logic [63:0]         r;
        longint              v;
        int                  h, pend_hits, sent, got, cyc;
        bit                  stall_prev, acc;
        logic [LANES*FW-1:0] exp_q [$];
        apply_reset();
        load_cfg(2, 2, 6, 5, 8, 1'b1, 1'b1, 0);
        sent = 0; got = 0; cyc = 0; stall_prev = 0; acc = 0; pend_hits = 0;
        while (got < NB && cyc < 20000) begin
            @(negedge system_clk);
            cyc++;
            if (!bus.data_in_valid && sent < NB && $urandom_range(0, 3) != 0) begin
                pend_hits = 0;
                for (int l = 0; l < LANES; l++) begin
                    r = {$urandom(), $urandom()};
                    v = $signed(r) >>> $urandom_range(28, 50);
                    pend_d[l*MW +: MW] = v[MW-1:0];
                    pend_e[l*FW +: FW] = model_lane(v, 2, 2, 3, 1'b1, 1'b1, 0, h);
                    pend_hits += h;
                end
                bus.data_in       = pend_d;
                bus.data_in_valid = 1'b1;
            end
            bus.act_data_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stall_prev) begin
                n_cmp++;
                if (bus.act_data_valid !== 1'b1 || bus.act_data !== stall_data) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b data=%h required 1 %h",
                             bus.act_data_valid, bus.act_data, stall_data);
                end
            end
            stall_prev = bus.act_data_valid && !bus.act_data_ready;
            stall_data = bus.act_data;
            if (bus.act_data_valid && bus.act_data_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra_beat: got %h required no beat", bus.act_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.act_data !== e) begin
                        n_err++;
                        $display("FAIL rand_beat%0d: got %h required %h", got, bus.act_data, e);
                    end
                end
                got++;
            end
            if (bus.data_in_valid && bus.data_in_ready) begin
                exp_q.push_back(pend_e);
                exp_sat = exp_sat + 32'(pend_hits);
                sent++;
                acc = 1;
            end
            @(posedge system_clk);
            #1;
            if (acc) bus.data_in_valid = 1'b0;
            acc = 0;
        end
        n_cmp++;
        if (got !== NB || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL rand_count: got %0d beats (%0d pending) required %0d (0)",
                     got, exp_q.size(), NB);
        end
        bus.act_data_ready = 1'b1;
        repeat (2) @(posedge system_clk);
        #1;
        n_cmp++;
        if (bus.act_data_valid !== 1'b0 || busy !== 1'b0 || sat_count !== exp_sat) begin
            n_err++;
            $display("FAIL rand_drain: valid=%b busy=%b sat=%0d required 0 0 %0d",
                     bus.act_data_valid, busy, sat_count, exp_sat);
        end
    endtask

    task automatic test_cfg_err_reset();
        // negative shift clamps to 0 and flags
        apply_reset();
        load_cfg(0, 0, 0, 0, 3, 1'b0, 1'b0, 0);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL neg_shift_err: got %b required 1", cfg_err);
        end
        lv = '{80, -80, 3, 0, 0, 0, 0, 0};
        ev = '{80, -80, 3, 0, 0, 0, 0, 0};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL neg_shift_data: got %h required %h", res, expv);
        end
        // load while busy is refused
        apply_reset();
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL busy_err_clear: got %b required 0", cfg_err);
        end
        lv = '{-7, 0, 0, 0, 0, 0, 0, 0};
        ev = '{-7, 0, 0, 0, 0, 0, 0, 0};
        expv = pack_out();
        @(negedge system_clk);
        bus.act_data_ready = 1'b0;
        bus.data_in        = pack_in();
        bus.data_in_valid  = 1'b1;
        @(posedge system_clk);
        #1 bus.data_in_valid = 1'b0;
        repeat (3) @(posedge system_clk);
        #1;
        n_cmp++;
        if (bus.act_data_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_busy: valid=%b busy=%b required 1 1", bus.act_data_valid, busy);
        end
        load_cfg(1, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (cfg_err !== 1'b1 || bus.act_data !== expv) begin
            n_err++;
            $display("FAIL busy_load: cfg_err=%b data=%h required 1 %h", cfg_err, bus.act_data,
                     expv);
        end
        @(negedge system_clk);
        bus.act_data_ready = 1'b1;
        @(posedge system_clk);
        #1;
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv) begin
            n_err++;
            $display("FAIL busy_cfg_kept: got %h required %h", res, expv);
        end
        // load coinciding with an accepted beat is refused
        apply_reset();
        lv = '{-3, 0, 0, 0, 0, 0, 0, 0};
        ev = '{-3, 0, 0, 0, 0, 0, 0, 0};
        expv = pack_out();
        @(negedge system_clk);
        cfg_act_mode      = 2'd1;
        cfg_load          = 1'b1;
        bus.data_in       = pack_in();
        bus.data_in_valid = 1'b1;
        @(posedge system_clk);
        #1;
        cfg_load          = 1'b0;
        bus.data_in_valid = 1'b0;
        repeat (3) @(posedge system_clk);
        #1;
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (cfg_err !== 1'b1 || res !== expv) begin
            n_err++;
            $display("FAIL same_cycle_load: cfg_err=%b data=%h required 1 %h", cfg_err, res, expv);
        end
        // reset mid-burst
        apply_reset();
        load_cfg(1, 0, 0, 0, 0, 1'b0, 1'b1, 0);
        lv = '{64'h10000, 0, 0, 0, 0, 0, 0, 0};
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (sat_count !== 32'd1) begin
            n_err++;
            $display("FAIL pre_reset_sat: got %0d required 1", sat_count);
        end
        @(negedge system_clk);
        bus.act_data_ready = 1'b0;
        bus.data_in_valid  = 1'b1;
        repeat (2) @(posedge system_clk);
        #1 bus.data_in_valid = 1'b0;
        @(negedge system_clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.act_data_valid !== 1'b0 || busy !== 1'b0 || sat_count !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b busy=%b sat=%0d required 0 0 0",
                     bus.act_data_valid, busy, sat_count);
        end
        exp_sat = '0;
        @(negedge system_clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.data_in_ready !== 1'b1 || cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: ready=%b cfg_err=%b required 1 0",
                     bus.data_in_ready, cfg_err);
        end
        lv = '{-9, 64'h10000, 0, 0, 0, 0, 0, 0};
        ev = '{-9, 0, 0, 0, 0, 0, 0, 0};
        expv = pack_out();
        run_beat(pack_in(), res, lat);
        n_cmp++;
        if (res !== expv || sat_count !== exp_sat) begin
            n_err++;
            $display("FAIL default_cfg: got %h sat %0d required %h sat %0d",
                     res, sat_count, expv, exp_sat);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        cfg_load           = 1'b0;
        cfg_act_mode       = '0;
        cfg_leaky_shift    = '0;
        cfg_fea_in_q       = '0;
        cfg_weight_q       = '0;
        cfg_fea_out_q      = '0;
        cfg_round_en       = 1'b0;
        cfg_sat_en         = 1'b0;
        cfg_clip_max       = '0;
        bus.data_in        = '0;
        bus.data_in_valid  = 1'b0;
        bus.act_data_ready = 1'b1;
        exp_sat            = '0;
        test_reset();
        test_bypass();
        test_relu_leaky();
        test_round_sat();
        test_clip_wrap();
        test_back_to_back();
        test_random_backpressure();
        test_cfg_err_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
